// File: rtl/multi_voice_tone_gen_pkg.sv
// Shared types and constants for the multi-voice square-wave tone generator.
// Holds the per-voice volume width, the config FSM states and the mixer shift helper.
package multi_voice_tone_gen_pkg;

  localparam int VOLUME_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } cfg_state_t;

  // Left-shift that scales the widest possible voice sum up to the full PWM counter range.
  function automatic int mix_shift(input int num_voices, input int pwm_bits);
    return pwm_bits - ($clog2(num_voices) + VOLUME_W);
  endfunction

endpackage

// File: rtl/multi_voice_tone_gen_square_voice.sv
// One square-wave voice: half-period divider, output level and stored volume.
// A load strobe replaces the settings and restarts the waveform from a low level.
module square_voice
  import multi_voice_tone_gen_pkg::*;
#(
  parameter int DIV_WIDTH = 20
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] load_half_period,
  input  logic [VOLUME_W-1:0]  load_volume,
  output logic                 level,
  output logic [VOLUME_W-1:0]  volume,
  output logic                 active
);

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] half_period;
  logic [DIV_WIDTH-1:0] count;

  // A zero half period parks the voice silent with the counter held at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      half_period <= '0;
      volume      <= '0;
      count       <= '0;
      level       <= 1'b0;
    end else if (load) begin
      half_period <= load_half_period;
      volume      <= load_volume;
      count       <= '0;
      level       <= 1'b0;
    end else if (half_period == '0) begin
      count <= '0;
      level <= 1'b0;
    end else if (count == half_period - ONE) begin
      count <= '0;
      level <= ~level;
    end else begin
      count <= count + ONE;
    end
  end

  assign active = (half_period != '0) && (volume != '0);

endmodule

// File: rtl/multi_voice_tone_gen.sv
// Multi-voice square-wave synthesiser: a handshaked config port, NUM_VOICES voices,
// a volume-weighted mixer and a PWM stage driving a mono amplifier.
module multi_voice_tone_gen
  import multi_voice_tone_gen_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int DIV_WIDTH  = 20,
  parameter int PWM_BITS   = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
  input  logic [DIV_WIDTH-1:0]          cfg_half_period,
  input  logic [VOLUME_W-1:0]           cfg_volume,
  output logic                          pwm_out,
  output logic                          gain,
  output logic                          shutdown_n,
  output logic [NUM_VOICES-1:0]         active_voices
);

  localparam int VOICE_W = $clog2(NUM_VOICES);
  localparam int SUM_W   = VOICE_W + VOLUME_W;
  localparam int SHIFT   = mix_shift(NUM_VOICES, PWM_BITS);

  cfg_state_t state;
  cfg_state_t state_next;
  logic       apply;

  logic [VOICE_W-1:0]   cap_voice;
  logic [DIV_WIDTH-1:0] cap_half_period;
  logic [VOLUME_W-1:0]  cap_volume;

  logic [NUM_VOICES-1:0] levels;
  logic [VOLUME_W-1:0]   volumes [NUM_VOICES];

  logic [SUM_W-1:0]    mix_sum;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Ready drops during reset and for the single APPLY cycle, so a held request is taken once.
  always_comb begin
    state_next = state;
    cfg_ready  = 1'b0;
    apply      = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = ~reset;
        if (cfg_valid && !reset) begin
          state_next = APPLY;
        end
      end
      APPLY: begin
        apply      = ~reset;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cap_voice       <= '0;
      cap_half_period <= '0;
      cap_volume      <= '0;
    end else if (cfg_valid && cfg_ready) begin
      cap_voice       <= cfg_voice;
      cap_half_period <= cfg_half_period;
      cap_volume      <= cfg_volume;
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    square_voice #(
      .DIV_WIDTH(DIV_WIDTH)
    ) u_voice (
      .clock           (clock),
      .reset           (reset),
      .load            (apply && (cap_voice == VOICE_W'(i))),
      .load_half_period(cap_half_period),
      .load_volume     (cap_volume),
      .level           (levels[i]),
      .volume          (volumes[i]),
      .active          (active_voices[i])
    );
  end

  // The sum is wide enough for every voice at full volume, so it cannot overflow.
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (levels[i]) begin
        mix_sum = mix_sum + SUM_W'(volumes[i]);
      end
    end
  end

  assign duty = PWM_BITS'(mix_sum) << SHIFT;

  // Duty only changes at the period boundary, so each PWM period is glitch-free.
  always_ff @(posedge clock) begin
    if (reset) begin
      pwm_cnt    <= '0;
      duty_q     <= '0;
      pwm_out    <= 1'b0;
      shutdown_n <= 1'b0;
    end else begin
      pwm_cnt    <= pwm_cnt + PWM_BITS'(1);
      if (pwm_cnt == '1) begin
        duty_q <= duty;
      end
      pwm_out    <= (pwm_cnt < duty_q);
      shutdown_n <= (active_voices != '0);
    end
  end

  assign gain = 1'b1;

endmodule

// File: tb/tb_multi_voice_tone_gen.sv
// Randomised scoreboard bench for multi_voice_tone_gen against a behavioural model
// that derives voice phases and PWM timing arithmetically from load times.
module tb_multi_voice_tone_gen;

  localparam int NUM_VOICES = 4;
  localparam int DIV_WIDTH  = 20;
  localparam int PWM_BITS   = 8;
  localparam int VOICE_W    = $clog2(NUM_VOICES);
  localparam int PSIZE      = 1 << PWM_BITS;
  localparam int SHIFT      = PWM_BITS - (VOICE_W + 4);

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [VOICE_W-1:0]    cfg_voice;
  logic [DIV_WIDTH-1:0]  cfg_half_period;
  logic [3:0]            cfg_volume;
  logic                  pwm_out;
  logic                  gain;
  logic                  shutdown_n;
  logic [NUM_VOICES-1:0] active_voices;

  multi_voice_tone_gen #(
    .NUM_VOICES(NUM_VOICES),
    .DIV_WIDTH (DIV_WIDTH),
    .PWM_BITS  (PWM_BITS)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_voice      (cfg_voice),
    .cfg_half_period(cfg_half_period),
    .cfg_volume     (cfg_volume),
    .pwm_out        (pwm_out),
    .gain           (gain),
    .shutdown_n     (shutdown_n),
    .active_voices  (active_voices)
  );

  always #5 clock = ~clock;

  typedef struct {
    int                    cyc;
    logic                  pwm;
    logic                  sd;
    logic [NUM_VOICES-1:0] act;
    logic                  rdy;
    logic                  gn;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  // Model: k counts clock edges since reset released; a voice loaded at edge L with
  // half period H has level floor((j-L)/H) mod 2 after edge j.
  int k;
  int m_hp   [NUM_VOICES];
  int m_vol  [NUM_VOICES];
  int m_load [NUM_VOICES];
  bit pend;
  int pend_v, pend_hp, pend_vol;
  int m_duty_q;
  bit m_pwm, m_sd;

  function automatic int voice_level(input int v, input int j);
    if (m_hp[v] == 0) return 0;
    return ((j - m_load[v]) / m_hp[v]) % 2;
  endfunction

  function automatic int mix_duty(input int j);
    int sum = 0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (voice_level(v, j) != 0) sum += m_vol[v];
    end
    return sum * (1 << SHIFT);
  endfunction

  function automatic logic [NUM_VOICES-1:0] active_mask();
    logic [NUM_VOICES-1:0] m = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      m[v] = (m_hp[v] != 0) && (m_vol[v] != 0);
    end
    return m;
  endfunction

  task automatic modelEdge();
    logic [NUM_VOICES-1:0] act_before;
    int cnt_before;
    if (reset) begin
      k = 0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        m_hp[v] = 0; m_vol[v] = 0; m_load[v] = 0;
      end
      pend = 0; m_duty_q = 0; m_pwm = 0; m_sd = 0;
    end else begin
      act_before = active_mask();
      k++;
      cnt_before = (k - 1) % PSIZE;
      m_pwm = (cnt_before < m_duty_q);
      if (cnt_before == PSIZE - 1) m_duty_q = mix_duty(k - 1);
      m_sd = (act_before != '0);
      if (pend) begin
        m_hp[pend_v]   = pend_hp;
        m_vol[pend_v]  = pend_vol;
        m_load[pend_v] = k;
        pend = 0;
      end else if (cfg_valid) begin
        pend     = 1;
        pend_v   = int'(cfg_voice);
        pend_hp  = int'(cfg_half_period);
        pend_vol = int'(cfg_volume);
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit valid, input int voice,
                               input int hp, input int vol);
    @(posedge clock);
    #1;
    cyc++;
    modelEdge();
    reset           = rst;
    cfg_valid       = valid;
    cfg_voice       = voice[VOICE_W-1:0];
    cfg_half_period = hp[DIV_WIDTH-1:0];
    cfg_volume      = vol[3:0];
    exp_q.push_back('{cyc, m_pwm, m_sd, active_mask(), !rst && !pend, 1'b1});
  endtask

  task automatic idle(input bit rst, input int n);
    repeat (n) applyStimulus(rst, 1'b0, 0, 0, 0);
  endtask

  task automatic configure(input int v, input int hp, input int vol);
    applyStimulus(1'b0, 1'b1, v, hp, vol);
    applyStimulus(1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic checkOutput(input string name, input int c, input logic [7:0] got,
                             input logic [7:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, c, got, want);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("pwm_out",       e.cyc, 8'(pwm_out),       8'(e.pwm));
      checkOutput("shutdown_n",    e.cyc, 8'(shutdown_n),    8'(e.sd));
      checkOutput("active_voices", e.cyc, 8'(active_voices), 8'(e.act));
      checkOutput("cfg_ready",     e.cyc, 8'(cfg_ready),     8'(e.rdy));
      checkOutput("gain",          e.cyc, 8'(gain),          8'(e.gn));
    end
  end

  initial begin
    int hold, hp, vol, v;
    reset = 1'b1; cfg_valid = 1'b0; cfg_voice = '0; cfg_half_period = '0; cfg_volume = '0;

    idle(1'b1, 3);
    idle(1'b0, 1000);

    configure(0, 4, 15);
    idle(1'b0, 600);

    // Request held across the APPLY cycle must still be taken only once.
    applyStimulus(1'b0, 1'b1, 1, 3, 7);
    applyStimulus(1'b0, 1'b1, 1, 3, 7);
    idle(1'b0, 20);

    for (int i = 0; i < NUM_VOICES; i++) configure(i, 1, 15);
    idle(1'b0, 600);

    idle(1'b1, 2);
    configure(0, 4, 15);
    idle(1'b0, 50);
    configure(0, 0, 15);
    idle(1'b0, 300);

    // Reset lands on the APPLY cycle, discarding the captured setting.
    applyStimulus(1'b0, 1'b1, 2, 5, 9);
    idle(1'b1, 1);
    idle(1'b0, 50);

    for (int t = 0; t < 60; t++) begin
      idle(1'b0, $urandom_range(0, 30));
      if ($urandom_range(0, 19) == 0) idle(1'b1, $urandom_range(1, 2));
      v    = $urandom_range(0, NUM_VOICES - 1);
      hp   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
      vol  = $urandom_range(0, 15);
      hold = $urandom_range(1, 3);
      repeat (hold) applyStimulus(1'b0, 1'b1, v, hp, vol);
      if ($urandom_range(0, 4) == 0) idle(1'b0, 300);
    end
    idle(1'b0, 20);

    repeat (2) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
